imm_encode_unit: RTL
====================

IMM_ENCODE_UNIT -- requirements
Module: imm_encode_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  a request is present on the input.
REQ-005 in_ready  out  1  the unit accepts the request this cycle.
REQ-006 imm_type  in  3  field layout: 000 I, 001 S, 010 B, 011 J, 100 U; 101-111 are illegal.
REQ-007 imm  in  32  the full 32-bit immediate value to encode.
REQ-008 out_valid  out  1  an encoded result is present on the outputs.
REQ-009 out_ready  in  1  the consumer accepts the result this cycle.
REQ-010 instr_field  out  25  instruction bits [31:7] holding the immediate; all non-immediate bits SHALL be 0.
REQ-011 range_err  out  1  imm is not representable in the selected layout.
REQ-012 type_err  out  1  imm_type is illegal.
REQ-013 err_count  out  8  saturating count of delivered results with range_err or type_err set.
REQ-014 roundtrip_err  out  1  the re-decoded field differs from imm (see REQ-031).

Function
REQ-015 A request SHALL transfer when in_valid and in_ready are both 1; a result SHALL transfer when out_valid and out_ready are both 1.
REQ-016 The datapath SHALL be a 2-stage pipeline: S1 registers the request plus its range/type check, and S2 registers the packed field.
REQ-017 Latency from input transfer to out_valid SHALL be exactly 2 cycles when there is no backpressure.
REQ-018 Sustained throughput SHALL be 1 result per cycle.
REQ-019 in_ready SHALL be 1 when S1 is empty or S1 advances this cycle; S1 SHALL advance when S2 is empty or S2 transfers this cycle.
REQ-020 While out_valid=1 and out_ready=0, all outputs SHALL hold stable, and results SHALL be delivered in input order.
REQ-021 Field packing, as field bit <= imm bit:
  - I: [24:13] <= [11:0].
  - S: [24:18] <= [11:5], [4:0] <= [4:0].
  - B: [24] <= [12], [23:18] <= [10:5], [4:1] <= [4:1], [0] <= [11].
  - J: [24] <= [20], [23:14] <= [10:1], [13] <= [11], [12:5] <= [19:12].
  - U: [24:5] <= [31:12].
REQ-022 range_err SHALL be set under these conditions:
  - I or S: imm[31:11] is not all-equal.
  - B: imm[31:12] is not all-equal, or imm[0]=1.
  - J: imm[31:20] is not all-equal, or imm[0]=1.
  - U: imm[11:0] is not 0.
REQ-023 When range_err=1, instr_field SHALL still carry the truncated packing defined in REQ-021.
REQ-024 For an illegal imm_type, type_err SHALL be 1, range_err SHALL be 0, and instr_field SHALL be 0.
REQ-025 err_count SHALL increment on each output transfer whose result has range_err or type_err set, and SHALL saturate at 255.

Reset
REQ-026 While reset is asserted, both stage-valid registers SHALL clear, out_valid SHALL be 0, and in_ready SHALL be 1 in the first cycle after reset.
REQ-027 While reset is asserted, instr_field, range_err, type_err, roundtrip_err and err_count SHALL be 0.
REQ-028 Asserting reset mid-operation SHALL discard all in-flight requests, and no result SHALL be delivered for them.
REQ-029 Reset SHALL take priority over every simultaneous transfer.

Configuration
REQ-030 Macro IMM_ENCODE_ROUNDTRIP_CHECK_EN SHALL control the round-trip check.
REQ-031 With IMM_ENCODE_ROUNDTRIP_CHECK_EN defined, S2 SHALL re-extend the packed field and register roundtrip_err = (re-extended value != imm) AND NOT range_err AND NOT type_err, aligned with out_valid.
REQ-032 Without IMM_ENCODE_ROUNDTRIP_CHECK_EN, roundtrip_err SHALL be tied to 0 and no decode logic SHALL be synthesized.

Structure
REQ-033 A shared package SHALL hold:
  - the imm_type enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U);
  - FIELD_W=25;
  - ERR_CNT_W=8.
REQ-034 The round-trip path SHALL be the sub-module imm_field_decode, a combinational 25-bit to 32-bit extender using the same type encoding, instantiated only under the macro.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
  - I, imm=0xFFFFF800 -> instr_field=0x1000000, range_err=0, 2 cycles after acceptance.
  - I, imm=0x00000800 -> instr_field=0x1000000, range_err=1, err_count 0->1.
  - B, imm=0x00000FFE -> instr_field=0x0FC001F, range_err=0; B, imm=0x00000FFF -> range_err=1.
  - U, imm=0x12345000 -> instr_field=0x02468A0; imm_type=3'b110 -> type_err=1, instr_field=0.
  - out_ready=0 while 3 back-to-back requests arrive -> in_ready=0 after 2 acceptances, outputs stable, then 3 in-order results once out_ready=1.
  - reset asserted with 2 requests in flight -> out_valid=0 next cycle, err_count=0, no stale result appears afterwards.

Source files
------------

// File: rtl/imm_encode_unit_pkg.sv
// Shared types and helpers for the immediate encoder.
// Field packing and range rules for RISC-V I/S/B/J/U layouts.
package imm_encode_unit_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_type_e;

    localparam int FIELD_W   = 25;
    localparam int ERR_CNT_W = 8;

    function automatic logic type_bad(input logic [2:0] t);
        return t > IMM_U;
    endfunction

    function automatic logic all_eq21(input logic [20:0] v);
        return (&v) | ~(|v);
    endfunction

    function automatic logic range_bad(input logic [2:0] t,
                                       input logic [31:0] v);
        logic bad;
        bad = 1'b0;
        case (t)
            IMM_I, IMM_S: bad = !all_eq21(v[31:11]);
            IMM_B:        bad = !all_eq21({v[31], v[31:12]}) | v[0];
            IMM_J:        bad = !all_eq21({{9{v[31]}}, v[31:20]}) | v[0];
            IMM_U:        bad = |v[11:0];
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [FIELD_W-1:0] pack_field(input logic [2:0] t,
                                                      input logic [31:0] v);
        logic [FIELD_W-1:0] f;
        f = '0;
        case (t)
            IMM_I: f = {v[11:0], 13'b0};
            IMM_S: f = {v[11:5], 13'b0, v[4:0]};
            IMM_B: f = {v[12], v[10:5], 13'b0, v[4:1], v[11]};
            IMM_J: f = {v[20], v[10:1], v[11], v[19:12], 5'b0};
            IMM_U: f = {v[31:12], 5'b0};
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_encode_unit_field_decode.sv
// Combinational re-extension of a packed 25-bit field to a 32-bit immediate.
module imm_field_decode
    import imm_encode_unit_pkg::*;
(
    input  logic [2:0]         imm_type,
    input  logic [FIELD_W-1:0] field,
    output logic [31:0]        imm
);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{20{field[24]}}, field[24:13]};
            IMM_S: imm = {{20{field[24]}}, field[24:18], field[4:0]};
            IMM_B: imm = {{20{field[24]}}, field[0], field[23:18],
                          field[4:1], 1'b0};
            IMM_J: imm = {{12{field[24]}}, field[12:5], field[13],
                          field[23:14], 1'b0};
            IMM_U: imm = {field[24:5], 12'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_encode_unit.sv
// Two-stage immediate encoder with valid/ready handshake on both sides.
// Optional round-trip self-check enabled by IMM_ENCODE_ROUNDTRIP_CHECK_EN.
module imm_encode_unit
    import imm_encode_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           imm_type,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FIELD_W-1:0]   instr_field,
    output logic                 range_err,
    output logic                 type_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 roundtrip_err
);

    logic               s1_valid;
    logic [2:0]         s1_type;
    logic [31:0]        s1_imm;
    logic               s1_range_err;
    logic               s1_type_err;
    logic               s2_ready;
    logic               out_fire;
    logic [FIELD_W-1:0] s1_field;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign out_fire = out_valid && out_ready;

    // Illegal types produce an all-zero field regardless of imm.
    assign s1_field = s1_type_err ? '0 : pack_field(s1_type, s1_imm);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_type      <= '0;
            s1_imm       <= '0;
            s1_range_err <= 1'b0;
            s1_type_err  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_type      <= imm_type;
                s1_imm       <= imm;
                s1_type_err  <= type_bad(imm_type);
                s1_range_err <= range_bad(imm_type, imm);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            instr_field <= '0;
            range_err   <= 1'b0;
            type_err    <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                instr_field <= s1_field;
                range_err   <= s1_range_err;
                type_err    <= s1_type_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (out_fire && (range_err || type_err) && !(&err_count)) begin
            err_count <= err_count + 1'b1;
        end
    end

`ifdef IMM_ENCODE_ROUNDTRIP_CHECK_EN
    logic [31:0] dec_imm;
    logic        rt_next;

    imm_field_decode u_decode (
        .imm_type (s1_type),
        .field    (s1_field),
        .imm      (dec_imm)
    );

    assign rt_next = (dec_imm != s1_imm) && !s1_range_err && !s1_type_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            roundtrip_err <= 1'b0;
        end else if (s2_ready && s1_valid) begin
            roundtrip_err <= rt_next;
        end
    end
`else
    assign roundtrip_err = 1'b0;
`endif

endmodule
